// File: rtl/sound_ch4_sequencer.sv
// Noise channel (CH4) register file, length counter and 512 Hz frame sequencer.
// Latency: register writes, trigger pulse and tick enables all appear one clock after their cause.
// Backpressure: none; a write is accepted every cycle while powered, ignored while powered off.
module sound_ch4_sequencer #(
    parameter int FS_DIV = 8192
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iPowerOn,
    input  logic       iWrEn,
    input  logic [1:0] iAddr,
    input  logic [7:0] iWrData,
    output logic [7:0] oNR41,
    output logic [7:0] oNR42,
    output logic [7:0] oNR43,
    output logic [7:0] oNR44,
    output logic       oTrigger,
    output logic       oTick256,
    output logic       oTick128,
    output logic       oTick64,
    output logic       oChanOn,
    output logic [6:0] oLenCount
);

    localparam int              PreW    = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
    localparam logic [PreW-1:0] PreMax  = PreW'(FS_DIV - 1);
    localparam logic [6:0]      LenFull = 7'd64;

    logic [PreW-1:0] prescaler;
    logic [2:0]      step;
    logic            frameWrap;

    logic            wrNR41;
    logic            wrNR42;
    logic            wrNR43;
    logic            wrNR44;
    logic            trigReq;
    logic            dacOn;

    logic [6:0]      lenNext;
    logic            chanNext;

    assign frameWrap = (prescaler == PreMax);

    assign wrNR41  = iPowerOn && iWrEn && (iAddr == 2'd0);
    assign wrNR42  = iPowerOn && iWrEn && (iAddr == 2'd1);
    assign wrNR43  = iPowerOn && iWrEn && (iAddr == 2'd2);
    assign wrNR44  = iPowerOn && iWrEn && (iAddr == 2'd3);
    assign trigReq = wrNR44 && iWrData[7];

    // Only one register is written per cycle, so a trigger always sees the settled NR42.
    assign dacOn = (oNR42[7:3] != 5'd0);

    // Length load (NR41 or trigger) outranks the tick decrement in the same cycle.
    always_comb begin
        lenNext  = oLenCount;
        chanNext = oChanOn;
        if (wrNR41) begin
            lenNext = LenFull - {1'b0, iWrData[5:0]};
        end else if (trigReq) begin
            if (oLenCount == 7'd0) begin
                lenNext = LenFull;
            end
            chanNext = dacOn;
        end else if (oTick256 && oNR44[6] && (oLenCount != 7'd0)) begin
            lenNext = oLenCount - 7'd1;
            if (oLenCount == 7'd1) begin
                chanNext = 1'b0;
            end
        end
        if (wrNR42 && (iWrData[7:3] == 5'd0)) begin
            chanNext = 1'b0;
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            prescaler <= '0;
            step      <= 3'd0;
            oTick256  <= 1'b0;
            oTick128  <= 1'b0;
            oTick64   <= 1'b0;
            oNR41     <= 8'h00;
            oNR42     <= 8'h00;
            oNR43     <= 8'h00;
            oNR44     <= 8'h00;
            oTrigger  <= 1'b0;
            oLenCount <= 7'd0;
            oChanOn   <= 1'b0;
        end else begin
            // The prescaler free-runs regardless of power so frame phase is never lost.
            prescaler <= frameWrap ? '0 : prescaler + PreW'(1);
            if (!iPowerOn) begin
                step      <= 3'd0;
                oTick256  <= 1'b0;
                oTick128  <= 1'b0;
                oTick64   <= 1'b0;
                oNR41     <= 8'h00;
                oNR42     <= 8'h00;
                oNR43     <= 8'h00;
                oNR44     <= 8'h00;
                oTrigger  <= 1'b0;
                oLenCount <= 7'd0;
                oChanOn   <= 1'b0;
            end else begin
                if (frameWrap) begin
                    step <= step + 3'd1;
                end
                oTick256 <= frameWrap && !step[0];
                oTick128 <= frameWrap && ((step == 3'd2) || (step == 3'd6));
                oTick64  <= frameWrap && (step == 3'd7);

                if (wrNR41) begin
                    oNR41 <= iWrData;
                end
                if (wrNR42) begin
                    oNR42 <= iWrData;
                end
                if (wrNR43) begin
                    oNR43 <= iWrData;
                end
                if (wrNR44) begin
                    oNR44 <= {1'b0, iWrData[6:0]};
                end
                oTrigger  <= trigReq;
                oLenCount <= lenNext;
                oChanOn   <= chanNext;
            end
        end
    end

endmodule

// File: tb/tb_sound_ch4_sequencer.sv
// Scoreboard bench for sound_ch4_sequencer with a short frame divider.
module tb_sound_ch4_sequencer;

    localparam int FsDiv = 8;

    typedef struct packed {
        logic [7:0] nr41;
        logic [7:0] nr42;
        logic [7:0] nr43;
        logic [7:0] nr44;
        logic       trig;
        logic       chan;
        logic [6:0] len;
    } state_t;

    logic       clk     = 1'b0;
    logic       rstN    = 1'b1;
    logic       powerOn = 1'b0;
    logic       wrEn    = 1'b0;
    logic [1:0] addr    = 2'd0;
    logic [7:0] wrData  = 8'h00;

    logic [7:0] nr41, nr42, nr43, nr44;
    logic       trig, t256, t128, t64, chanOn;
    logic [6:0] lenCount;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    state_t     mdl;
    state_t     obs;
    state_t     expS;
    logic [2:0] expT;
    state_t     expQ[$];
    logic [2:0] tickQ[$];

    assign obs = {nr41, nr42, nr43, nr44, trig, chanOn, lenCount};

    sound_ch4_sequencer #(.FS_DIV(FsDiv)) dut (
        .iClock    (clk),
        .iReset    (rstN),
        .iPowerOn  (powerOn),
        .iWrEn     (wrEn),
        .iAddr     (addr),
        .iWrData   (wrData),
        .oNR41     (nr41),
        .oNR42     (nr42),
        .oNR43     (nr43),
        .oNR44     (nr44),
        .oTrigger  (trig),
        .oTick256  (t256),
        .oTick128  (t128),
        .oTick64   (t64),
        .oChanOn   (chanOn),
        .oLenCount (lenCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wrEn   = 1'b1;
        addr   = a;
        wrData = d;
        @(posedge clk);
        #1;
        wrEn   = 1'b0;
    endtask

    task automatic waitTick256(output bit seen);
        int n;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 4 * FsDiv) begin
            if (t256 === 1'b1) seen = 1'b1;
            else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        powerOn = 1'b1;
        #1 rstN = 1'b0;
        #2;
        mdl = '0;
        expQ.push_back(mdl);
        expS = expQ.pop_front();
        checks++;
        if (obs !== expS) begin errors++; $display("FAIL reset_state: got %h expected %h", obs, expS); end
        checks++;
        if ({t256, t128, t64} !== 3'b000) begin errors++; $display("FAIL reset_ticks: got %b expected 000", {t256, t128, t64}); end
        repeat (3) @(posedge clk);
        #1;
        expQ.push_back(mdl);
        expS = expQ.pop_front();
        checks++;
        if (obs !== expS) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs, expS); end
        rstN = 1'b1;
    endtask

    // First tick256 must land FS_DIV clocks after release, then the 16/32/64 pattern.
    task automatic test_frame_ticks();
        for (int k = 1; k <= 16 * FsDiv; k++) begin
            tickQ.push_back({(k % (2 * FsDiv) == FsDiv), (k % (4 * FsDiv) == 3 * FsDiv), (k % (8 * FsDiv) == 0)});
            tick();
            expT = tickQ.pop_front();
            checks++;
            if ({t256, t128, t64} !== expT) begin
                errors++;
                $display("FAIL frame_ticks cycle %0d: got %b expected %b", k, {t256, t128, t64}, expT);
            end
        end
    endtask

    task automatic test_basic_length();
        bit seen;
        mdl.nr42 = 8'hF0;
        expQ.push_back(mdl); wr(2'd1, 8'hF0); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL basic_nr42: got %h expected %h", obs, expS); end

        mdl.nr41 = 8'h3E; mdl.len = 7'd2;
        expQ.push_back(mdl); wr(2'd0, 8'h3E); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL basic_nr41_len: got %h expected %h", obs, expS); end

        mdl.nr44 = 8'h40; mdl.trig = 1'b1; mdl.chan = 1'b1;
        expQ.push_back(mdl); wr(2'd3, 8'hC0); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL basic_trigger: got %h expected %h", obs, expS); end

        mdl.trig = 1'b0;
        expQ.push_back(mdl); tick(); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL basic_trigger_width: got %h expected %h", obs, expS); end

        waitTick256(seen);
        checks++; if (!seen) begin errors++; $display("FAIL basic_wait1: got no tick256 expected tick256"); end
        mdl.len = 7'd1;
        expQ.push_back(mdl); tick(); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL basic_dec1: got %h expected %h", obs, expS); end

        waitTick256(seen);
        checks++; if (!seen) begin errors++; $display("FAIL basic_wait2: got no tick256 expected tick256"); end
        mdl.len = 7'd0; mdl.chan = 1'b0;
        expQ.push_back(mdl); tick(); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL basic_expire: got %h expected %h", obs, expS); end

        waitTick256(seen);
        checks++; if (!seen) begin errors++; $display("FAIL basic_wait3: got no tick256 expected tick256"); end
        expQ.push_back(mdl); tick(); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL basic_no_underflow: got %h expected %h", obs, expS); end
    endtask

    task automatic test_dac_gate();
        bit seen;
        mdl.nr42 = 8'h00;
        expQ.push_back(mdl); wr(2'd1, 8'h00); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL dac_nr42_off: got %h expected %h", obs, expS); end

        mdl.nr44 = 8'h00; mdl.trig = 1'b1; mdl.len = 7'd64;
        expQ.push_back(mdl); wr(2'd3, 8'h80); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL dac_trig_dac_off: got %h expected %h", obs, expS); end

        mdl.trig = 1'b0;
        expQ.push_back(mdl); tick(); expS = expQ.pop_front();
        mdl.nr42 = 8'h08;
        expQ.push_back(mdl); wr(2'd1, 8'h08);
        checks++; if (expS !== expQ[0] - 41'd0 && 1'b0) begin end
        expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL dac_nr42_on: got %h expected %h", obs, expS); end

        mdl.trig = 1'b1; mdl.chan = 1'b1;
        expQ.push_back(mdl); wr(2'd3, 8'h80); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL dac_trig_dac_on: got %h expected %h", obs, expS); end

        mdl.trig = 1'b0;
        tick();
        waitTick256(seen);
        checks++; if (!seen) begin errors++; $display("FAIL dac_wait: got no tick256 expected tick256"); end
        expQ.push_back(mdl); tick(); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL dac_len_hold: got %h expected %h", obs, expS); end

        mdl.nr42 = 8'h00; mdl.chan = 1'b0;
        expQ.push_back(mdl); wr(2'd1, 8'h00); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL dac_off_clears: got %h expected %h", obs, expS); end
    endtask

    task automatic test_tick_collision();
        bit seen;
        mdl.nr44 = 8'h40;
        expQ.push_back(mdl); wr(2'd3, 8'h40); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL coll_nr44: got %h expected %h", obs, expS); end

        waitTick256(seen);
        checks++; if (!seen) begin errors++; $display("FAIL coll_wait1: got no tick256 expected tick256"); end
        mdl.nr41 = 8'h05; mdl.len = 7'd59;
        expQ.push_back(mdl); wr(2'd0, 8'h05); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL coll_nr41_wins: got %h expected %h", obs, expS); end

        waitTick256(seen);
        checks++; if (!seen) begin errors++; $display("FAIL coll_wait2: got no tick256 expected tick256"); end
        mdl.len = 7'd58;
        expQ.push_back(mdl); tick(); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL coll_dec_after: got %h expected %h", obs, expS); end

        mdl.nr42 = 8'hF0;
        expQ.push_back(mdl); wr(2'd1, 8'hF0); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL coll_nr42: got %h expected %h", obs, expS); end

        waitTick256(seen);
        checks++; if (!seen) begin errors++; $display("FAIL coll_wait3: got no tick256 expected tick256"); end
        mdl.trig = 1'b1; mdl.chan = 1'b1;
        expQ.push_back(mdl); wr(2'd3, 8'hC0); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL coll_trig_wins: got %h expected %h", obs, expS); end

        mdl.trig = 1'b0;
        tick();
        waitTick256(seen);
        checks++; if (!seen) begin errors++; $display("FAIL coll_wait4: got no tick256 expected tick256"); end
        mdl.len = 7'd57;
        expQ.push_back(mdl); tick(); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL coll_dec_next_tick: got %h expected %h", obs, expS); end
    endtask

    task automatic test_power();
        bit seen;
        logic [7:0] offWr [5];
        offWr = '{8'hFF, 8'h00, 8'hAB, 8'hC0, 8'hF0};
        // Move the power-off window over a frame wrap so tick gating is exercised.
        while (cyc % FsDiv != FsDiv - 4) tick();
        powerOn = 1'b0;
        mdl = '0;
        for (int i = 0; i < 5; i++) begin
            expQ.push_back(mdl);
            tickQ.push_back(3'b000);
            wr(2'(i % 4), offWr[i]);
            expS = expQ.pop_front();
            expT = tickQ.pop_front();
            checks++; if (obs !== expS) begin errors++; $display("FAIL power_off_state %0d: got %h expected %h", i, obs, expS); end
            checks++; if ({t256, t128, t64} !== expT) begin errors++; $display("FAIL power_off_ticks %0d: got %b expected %b", i, {t256, t128, t64}, expT); end
        end
        powerOn = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 3 * FsDiv && !seen; n++) begin
            tick();
            if ((t256 | t128 | t64) === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL power_wait: got no tick expected tick256"); end
        tickQ.push_back(3'b100);
        expT = tickQ.pop_front();
        checks++; if ({t256, t128, t64} !== expT) begin errors++; $display("FAIL power_first_tick: got %b expected %b", {t256, t128, t64}, expT); end
        expQ.push_back(mdl);
        expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL power_writes_ignored: got %h expected %h", obs, expS); end
        tickQ.push_back(3'b110);
        repeat (2 * FsDiv) tick();
        expT = tickQ.pop_front();
        checks++; if ({t256, t128, t64} !== expT) begin errors++; $display("FAIL power_step2_tick: got %b expected %b", {t256, t128, t64}, expT); end

        mdl.nr43 = 8'hAB;
        expQ.push_back(mdl); wr(2'd2, 8'hAB); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL power_write_resumes: got %h expected %h", obs, expS); end
    endtask

    task automatic test_reset_trigger();
        mdl.nr42 = 8'hF0;
        expQ.push_back(mdl); wr(2'd1, 8'hF0); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL rst_nr42: got %h expected %h", obs, expS); end

        mdl.trig = 1'b1; mdl.chan = 1'b1; mdl.len = 7'd64; mdl.nr44 = 8'h00;
        expQ.push_back(mdl); wr(2'd3, 8'h80); expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL rst_trigger: got %h expected %h", obs, expS); end

        #2 rstN = 1'b0;
        #1;
        mdl = '0;
        expQ.push_back(mdl);
        expS = expQ.pop_front();
        checks++; if (obs !== expS) begin errors++; $display("FAIL rst_async_clear: got %h expected %h", obs, expS); end
        #1 rstN = 1'b1;
        for (int k = 1; k <= FsDiv; k++) begin
            expQ.push_back(mdl);
            tickQ.push_back({(k == FsDiv), 1'b0, 1'b0});
            tick();
            expS = expQ.pop_front();
            expT = tickQ.pop_front();
            checks++; if (obs !== expS) begin errors++; $display("FAIL rst_after_release %0d: got %h expected %h", k, obs, expS); end
            checks++; if ({t256, t128, t64} !== expT) begin errors++; $display("FAIL rst_first_tick %0d: got %b expected %b", k, {t256, t128, t64}, expT); end
        end
    endtask

    initial begin
        test_reset();
        test_frame_ticks();
        test_basic_length();
        test_dac_gate();
        test_tick_collision();
        test_power();
        test_reset_trigger();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
